linebuf_window_ctrl: RTL

Frame sequencer for the 3-line buffer datapath. It sits between the pixel source and the line-buffer stack. It accepts a raster pixel stream framed by a start-of-frame marker and gates writes into the line buffers. It tracks column and row position and reports when the three row taps form a complete 3x3 window, with line and frame boundary flags and frame-done and error pulses.

---
 rtl/linebuf_window_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/linebuf_window_ctrl.sv
// Frame sequencer in front of a 3-line buffer: gates pixel writes and tracks column/row position.
// Window outputs are registered one cycle after the accepting pixel; there is no back-pressure, so unaccepted pixels are dropped.
module linebuf_window_ctrl #(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             buf_in_valid,
    output logic             win_valid,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             win_eol,
    output logic             win_eof,
    output logic             busy,
    output logic             frame_done,
    output logic             sof_err
);

    typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DONE} state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               win_valid_q, win_valid_d;
    logic [COL_W-1:0]   win_col_q, win_col_d;
    logic [ROW_W-1:0]   win_row_q, win_row_d;
    logic               win_eol_q, win_eol_d;
    logic               win_eof_q, win_eof_d;
    logic               sof_err_q, sof_err_d;

    logic               in_frame, start_acc, mid_sof, accept;
    logic [COL_W-1:0]   pix_col;
    logic [ROW_W-1:0]   pix_row;
    logic               pix_last_col, pix_last;

    // Position of the pixel being accepted this cycle; any sof restarts at (0,0).
    always_comb begin
        in_frame     = (state_q == PRIME) || (state_q == ACTIVE);
        start_acc    = pix_valid && pix_sof && enable && !in_frame;
        mid_sof      = pix_valid && pix_sof && in_frame;
        accept       = rst_n && pix_valid && (in_frame || start_acc);
        pix_col      = (start_acc || mid_sof) ? '0 : col_q;
        pix_row      = (start_acc || mid_sof) ? '0 : row_q;
        pix_last_col = (pix_col == COL_LAST);
        pix_last     = pix_last_col && (pix_row == ROW_LAST);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pix_last_col) begin
                col_d = '0;
                row_d = pix_last ? '0 : pix_row + ROW_W'(1);
            end else begin
                col_d = pix_col + COL_W'(1);
                row_d = pix_row;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_acc) state_d = PRIME;
            PRIME:  if (accept && pix_last_col && pix_row == ROW_W'(1)) state_d = ACTIVE;
            ACTIVE: begin
                if (mid_sof)                 state_d = PRIME;
                else if (accept && pix_last) state_d = DONE;
            end
            DONE:   state_d = start_acc ? PRIME : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A window's bottom-right pixel is (c,r); its top-left corner is reported.
    always_comb begin
        win_valid_d = accept && (pix_col >= COL_W'(2)) && (pix_row >= ROW_W'(2));
        win_col_d   = win_valid_d ? pix_col - COL_W'(2) : win_col_q;
        win_row_d   = win_valid_d ? pix_row - ROW_W'(2) : win_row_q;
        win_eol_d   = win_valid_d && pix_last_col;
        win_eof_d   = win_eol_d && (pix_row == ROW_LAST);
        sof_err_d   = rst_n && mid_sof;
    end

    always_comb begin
        buf_in_valid = accept;
        busy         = in_frame;
        frame_done   = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            win_eol_q   <= 1'b0;
            win_eof_q   <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            win_eol_q   <= win_eol_d;
            win_eof_q   <= win_eof_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_col   = win_col_q;
    assign win_row   = win_row_q;
    assign win_eol   = win_eol_q;
    assign win_eof   = win_eof_q;
    assign sof_err   = sof_err_q;

endmodule
